// File: rtl/vend_pkg.sv
// Shared definitions for the multi-item vending controller: state encoding
// and small elaboration-time helpers.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PAY    = 3'd1,
        ST_VEND   = 3'd2,
        ST_CHANGE = 3'd3
    } vend_state_t;

    localparam int STATE_W = 3;

    // Width of a counter that must be able to hold max_count itself.
    function automatic int counter_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/vend_change_pick.sv
// Combinational change selector: picks the largest coin not exceeding the
// remaining credit, or flags that no coin fits.
module vend_change_pick
    import vend_pkg::*;
#(
    parameter int MONEY_W = 13,
    parameter int N_COINS = 4,
    parameter logic [N_COINS*MONEY_W-1:0] COIN_VAL = {MONEY_W'(100), MONEY_W'(25), MONEY_W'(10), MONEY_W'(5)}
) (
    input  logic [MONEY_W-1:0] remainder,
    output logic [N_COINS-1:0] pick,
    output logic [MONEY_W-1:0] pick_val,
    output logic               none_fits
);

    // Coins are ascending, so the last fitting index is the largest coin.
    always_comb begin
        pick      = '0;
        pick_val  = '0;
        none_fits = 1'b1;
        for (int i = 0; i < N_COINS; i++) begin
            if (COIN_VAL[i*MONEY_W +: MONEY_W] <= remainder) begin
                pick      = '0;
                pick[i]   = 1'b1;
                pick_val  = COIN_VAL[i*MONEY_W +: MONEY_W];
                none_fits = 1'b0;
            end
        end
    end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Parametrised vending controller: validates an item code against a price/stock
// table, accumulates coin credit, vends, then pays change one coin per tick.
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int CODE_W     = 4,
    parameter int N_ITEMS    = 16,
    parameter int MONEY_W    = 13,
    parameter int N_COINS    = 4,
    parameter logic [N_COINS*MONEY_W-1:0] COIN_VAL  = {MONEY_W'(100), MONEY_W'(25), MONEY_W'(10), MONEY_W'(5)},
    parameter logic [N_ITEMS*MONEY_W-1:0] PRICE_TBL = {N_ITEMS{MONEY_W'(65)}},
    parameter int TIMEOUT_TK = 30000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [N_COINS-1:0]   coin_in,
    input  logic [CODE_W-1:0]    code_in,
    input  logic                 code_valid,
    input  logic                 cancel,
    input  logic [N_ITEMS-1:0]   sold_out,
    output logic [STATE_W-1:0]   state,
    output logic [MONEY_W-1:0]   credit,
    output logic [MONEY_W-1:0]   price,
    output logic                 dispense,
    output logic [CODE_W-1:0]    item,
    output logic [N_COINS-1:0]   change_coin,
    output logic [N_COINS-1:0]   coin_reject,
    output logic                 err,
    output logic                 change_short
);

    localparam int SUM_W = MONEY_W + $clog2(N_COINS) + 1;
    localparam int TMO_W = counter_width(TIMEOUT_TK);
    localparam logic [MONEY_W-1:0] MAX_CREDIT = {MONEY_W{1'b1}};

    vend_state_t          state_q, state_d;
    logic [MONEY_W-1:0]   credit_q, credit_d;
    logic [MONEY_W-1:0]   price_q, price_d;
    logic [CODE_W-1:0]    item_q, item_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 dispense_d, err_d, change_short_d;
    logic [N_COINS-1:0]   change_coin_d, coin_reject_d;

    logic [SUM_W-1:0]     coin_total;
    logic [SUM_W-1:0]     sum_credit;
    logic                 overflow;
    logic                 sel_hit;
    logic                 sel_sold;
    logic [MONEY_W-1:0]   sel_price;
    logic [N_COINS-1:0]   pick;
    logic [MONEY_W-1:0]   pick_val;
    logic                 none_fits;

    vend_change_pick #(
        .MONEY_W  (MONEY_W),
        .N_COINS  (N_COINS),
        .COIN_VAL (COIN_VAL)
    ) u_pick (
        .remainder (credit_q),
        .pick      (pick),
        .pick_val  (pick_val),
        .none_fits (none_fits)
    );

    // Sum of this cycle's coins, widened so an overflow can be detected.
    always_comb begin
        coin_total = '0;
        for (int i = 0; i < N_COINS; i++) begin
            if (coin_in[i]) begin
                coin_total = coin_total + SUM_W'(COIN_VAL[i*MONEY_W +: MONEY_W]);
            end
        end
        sum_credit = SUM_W'(credit_q) + coin_total;
        overflow   = sum_credit > SUM_W'(MAX_CREDIT);
    end

    // Table lookup by comparison so out-of-range codes simply miss.
    always_comb begin
        sel_hit   = 1'b0;
        sel_sold  = 1'b0;
        sel_price = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (32'(code_in) == 32'(i)) begin
                sel_hit   = 1'b1;
                sel_sold  = sold_out[i];
                sel_price = PRICE_TBL[i*MONEY_W +: MONEY_W];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        price_d        = price_q;
        item_d         = item_q;
        tmo_d          = tmo_q;
        dispense_d     = 1'b0;
        err_d          = 1'b0;
        change_short_d = 1'b0;
        change_coin_d  = '0;
        coin_reject_d  = '0;
        unique case (state_q)
            ST_IDLE: begin
                coin_reject_d = coin_in;
                if (code_valid) begin
                    item_d = code_in;
                    if (!sel_hit || sel_price == '0 || sel_sold) begin
                        err_d = 1'b1;
                    end else begin
                        price_d = sel_price;
                        tmo_d   = '0;
                        state_d = ST_PAY;
                    end
                end
            end
            ST_PAY: begin
                if (overflow) begin
                    coin_reject_d = coin_in;
                end else begin
                    credit_d = sum_credit[MONEY_W-1:0];
                end
                if (coin_in != '0 && !overflow) begin
                    tmo_d = '0;
                end else if (tick) begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
                // Cancel and timeout win over vending; accepted coins are refunded.
                if (cancel || tmo_q == TMO_W'(TIMEOUT_TK)) begin
                    state_d = ST_CHANGE;
                end else if (credit_d >= price_q) begin
                    dispense_d = 1'b1;
                    state_d    = ST_VEND;
                end
            end
            ST_VEND: begin
                coin_reject_d = coin_in;
                credit_d      = credit_q - price_q;
                state_d       = ST_CHANGE;
            end
            ST_CHANGE: begin
                coin_reject_d = coin_in;
                if (tick) begin
                    if (credit_q == '0) begin
                        price_d = '0;
                        state_d = ST_IDLE;
                    end else if (none_fits) begin
                        change_short_d = 1'b1;
                        credit_d       = '0;
                        price_d        = '0;
                        state_d        = ST_IDLE;
                    end else begin
                        change_coin_d = pick;
                        credit_d      = credit_q - pick_val;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            credit_q     <= '0;
            price_q      <= '0;
            item_q       <= '0;
            tmo_q        <= '0;
            dispense     <= 1'b0;
            err          <= 1'b0;
            change_short <= 1'b0;
            change_coin  <= '0;
            coin_reject  <= '0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            price_q      <= price_d;
            item_q       <= item_d;
            tmo_q        <= tmo_d;
            dispense     <= dispense_d;
            err          <= err_d;
            change_short <= change_short_d;
            change_coin  <= change_coin_d;
            coin_reject  <= coin_reject_d;
        end
    end

    assign state  = state_q;
    assign credit = credit_q;
    assign price  = price_q;
    assign item   = item_q;

endmodule
